// File: rtl/ifetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, captures the combinational imem
// word into a small prefetch FIFO, and hands entries to decode over valid/ready.
// Redirects flush the FIFO and restart fetch; halt stops new fetches only.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        halt,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        fault_misalign
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [31:0]      fetch_pc_q;
    logic [31:0]      ent_pc_q    [FIFO_DEPTH];
    logic [31:0]      ent_instr_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             fault_q;
    logic             empty;
    logic             full;
    logic             pop;
    logic             push;

    assign imem_addr      = fetch_pc_q;
    assign fault_misalign = fault_q;

    // Handshake decode, head presentation and occupancy next-state.
    always_comb begin
        empty     = (count_q == '0);
        full      = (count_q == CNT_W'(FIFO_DEPTH));
        // A redirect hides the head so nothing stale is accepted in the flush cycle.
        out_valid = !empty && !redirect_valid;
        pop       = out_valid && out_ready;
        // Full is fine as long as the head leaves in the same cycle.
        push      = !redirect_valid && !halt && (!full || pop);
        out_instr = empty ? NOP_INSTR : ent_instr_q[rd_ptr_q];
        out_pc    = empty ? 32'h0 : ent_pc_q[rd_ptr_q];
        count_d   = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Fetch PC, FIFO storage/pointers and misalign pulse register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            fault_q    <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                ent_pc_q[i]    <= 32'h0;
                ent_instr_q[i] <= NOP_INSTR;
            end
        end else begin
            fault_q <= redirect_valid && (redirect_pc[1:0] != 2'b00);
            if (redirect_valid) begin
                // Low bits are dropped; the fault pulse reports the misalignment.
                fetch_pc_q <= {redirect_pc[31:2], 2'b00};
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                count_q    <= '0;
            end else begin
                if (push) begin
                    ent_pc_q[wr_ptr_q]    <= fetch_pc_q;
                    ent_instr_q[wr_ptr_q] <= imem_instr;
                    wr_ptr_q              <= wr_ptr_q + PTR_W'(1);
                    fetch_pc_q            <= fetch_pc_q + 32'd4;
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                end
                count_q <= count_d;
            end
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios followed by random traffic, all checked
// against a queue-based model of the fetch stream.
module tb_ifetch_unit;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam int          DEPTH = 2;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        halt = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fault_misalign;

    int tests = 0;
    int failed = 0;

    // Model state
    ent_t        q[$];
    logic [31:0] m_pc;
    logic        m_fault;

    // Last sampled DUT outputs
    logic        s_valid;
    logic [31:0] s_pc;
    logic [31:0] s_instr;
    logic [31:0] s_addr;
    logic        s_fault;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    assign imem_instr = mem_word(imem_addr);

    ifetch_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_addr     (imem_addr),
        .imem_instr    (imem_instr),
        .halt          (halt),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .fault_misalign(fault_misalign)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Assert reset partway through the high phase and check the immediate effect.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_valid", {31'h0, out_valid}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_instr", out_instr, NOP);
        chk("rst_pc", out_pc, 32'h0);
        chk("rst_fault", {31'h0, fault_misalign}, 32'd0);
        q.delete();
        m_pc    = 32'h0;
        m_fault = 1'b0;
    endtask

    // One clock: drive inputs, compare outputs with the model, then advance the model.
    task automatic cycle(input logic rv, input logic [31:0] rpc, input logic h,
                         input logic rdy);
        logic        e_valid;
        logic        do_pop;
        logic        do_push;
        ent_t        e;
        @(negedge clk);
        rst_n          = 1'b1;
        redirect_valid = rv;
        redirect_pc    = rpc;
        halt           = h;
        out_ready      = rdy;
        #1;
        e_valid = (q.size() != 0) && !rv;
        s_valid = out_valid;
        s_pc    = out_pc;
        s_instr = out_instr;
        s_addr  = imem_addr;
        s_fault = fault_misalign;
        chk("valid", {31'h0, s_valid}, {31'h0, e_valid});
        chk("pc", s_pc, (q.size() != 0) ? q[0].pc : 32'h0);
        chk("instr", s_instr, (q.size() != 0) ? q[0].instr : NOP);
        chk("addr", s_addr, m_pc);
        chk("fault", {31'h0, s_fault}, {31'h0, m_fault});
        @(posedge clk);
        m_fault = rv && (rpc[1:0] != 2'b00);
        if (rv) begin
            q.delete();
            m_pc = {rpc[31:2], 2'b00};
        end else begin
            do_pop  = e_valid && rdy;
            do_push = !h && ((q.size() < DEPTH) || do_pop);
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                e.pc    = m_pc;
                e.instr = mem_word(m_pc);
                q.push_back(e);
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    initial begin
        logic        rv;
        logic        h;
        logic        rdy;
        logic [31:0] rpc;

        // T1: reset, then free-running fetch
        do_reset();
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        chk("t1_c0_valid", {31'h0, s_valid}, 32'd0);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        chk("t1_c1_pc", s_pc, 32'h0);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        chk("t1_c2_pc", s_pc, 32'h4);
        chk("t1_c2_instr", s_instr, mem_word(32'h4));
        repeat (5) cycle(1'b0, 32'h0, 1'b0, 1'b1);

        // Mid-stream reset drops everything immediately
        chk("t6_pre_valid", {31'h0, s_valid}, 32'd1);
        do_reset();

        // T2: backpressure from the start
        repeat (6) cycle(1'b0, 32'h0, 1'b0, 1'b0);
        chk("t2_addr", s_addr, 32'h8);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        chk("t2_pc0", s_pc, 32'h0);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        chk("t2_pc4", s_pc, 32'h4);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        chk("t2_pc8", s_pc, 32'h8);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        chk("t2_pcc", s_pc, 32'hC);

        // T3: redirect with two buffered entries
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b1, 32'h100, 1'b0, 1'b1);
        chk("t3_n_valid", {31'h0, s_valid}, 32'd0);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        chk("t3_n1_valid", {31'h0, s_valid}, 32'd0);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        chk("t3_n2_valid", {31'h0, s_valid}, 32'd1);
        chk("t3_n2_pc", s_pc, 32'h100);

        // T4: misaligned redirect
        cycle(1'b1, 32'h102, 1'b0, 1'b1);
        chk("t4_n_fault", {31'h0, s_fault}, 32'd0);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        chk("t4_n1_fault", {31'h0, s_fault}, 32'd1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        chk("t4_n2_fault", {31'h0, s_fault}, 32'd0);
        chk("t4_n2_pc", s_pc, 32'h100);

        // T5: address wrap
        cycle(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        chk("t5_pc_top", s_pc, 32'hFFFF_FFFC);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        chk("t5_pc_wrap", s_pc, 32'h0);

        // T6: halt drains exactly the buffered entries
        repeat (3) cycle(1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b1);
        chk("t6_h0_valid", {31'h0, s_valid}, 32'd1);
        cycle(1'b0, 32'h0, 1'b1, 1'b1);
        chk("t6_h1_valid", {31'h0, s_valid}, 32'd1);
        cycle(1'b0, 32'h0, 1'b1, 1'b1);
        chk("t6_h2_valid", {31'h0, s_valid}, 32'd0);
        cycle(1'b0, 32'h0, 1'b1, 1'b1);
        chk("t6_h3_valid", {31'h0, s_valid}, 32'd0);

        // Redirect while halted: PC moves, nothing fetched until halt drops
        cycle(1'b1, 32'h200, 1'b1, 1'b1);
        cycle(1'b0, 32'h0, 1'b1, 1'b1);
        cycle(1'b0, 32'h0, 1'b1, 1'b1);
        chk("rh_valid", {31'h0, s_valid}, 32'd0);
        chk("rh_addr", s_addr, 32'h200);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        chk("rh_pc", s_pc, 32'h200);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            rv  = ($urandom_range(0, 11) == 0);
            rpc = $urandom;
            if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
            if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFF8;
            h   = ($urandom_range(0, 6) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            cycle(rv, rpc, h, rdy);
            if (i == 200) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
